// File: rtl/fp_add_pipe.sv
// Three-stage pipelined IEEE-754 binary adder/subtractor with valid/ready flow control.
// Stage 1 aligns the operands, stage 2 adds and counts leading zeros, stage 3 normalises and rounds.
module fp_add_pipe #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   in_a,
  input  logic [EXP_W+MAN_W:0]   in_b,
  input  logic                   in_op,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   out_result,
  output logic [2:0]             out_flags
);

  localparam int unsigned W   = 1 + EXP_W + MAN_W;
  localparam int unsigned FW  = MAN_W + 4;            // hidden, mantissa, guard, round, sticky
  localparam int unsigned SW  = MAN_W + 5;            // FW plus carry-out
  localparam int unsigned LZW = $clog2(MAN_W + 6);
  localparam int unsigned SHW = ((EXP_W > LZW) ? EXP_W : LZW) + 1;
  localparam int unsigned EW  = EXP_W + 1;
  localparam int unsigned PW  = EXP_W + 1 + MAN_W;

  logic stall, adv;
  logic out_valid_q;
  logic [W-1:0] out_result_q;
  logic [2:0] out_flags_q;

  assign stall      = out_valid_q & ~out_ready;
  assign adv        = ~stall;
  assign in_ready   = adv;
  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_flags  = out_flags_q;

  // Stage 1: unpack, classify, order by magnitude and align the smaller operand.
  logic sa, sb, a_nan, b_nan, a_inf, b_inf, b_gt;
  logic [EXP_W-1:0] ea, eb, ea_e, eb_e, el, es, diff;
  logic [MAN_W-1:0] ma, mb;
  logic [FW-1:0] ext_l, ext_s, sh_s;
  logic [2*FW-1:0] wide;
  logic s1_sign_d, s1_sub_d, s1_nan_d, s1_inf_d, s1_inf_sign_d;

  always_comb begin
    sa    = in_a[W-1];
    sb    = in_b[W-1] ^ in_op;
    ea    = in_a[W-2:MAN_W];
    eb    = in_b[W-2:MAN_W];
    ma    = in_a[MAN_W-1:0];
    mb    = in_b[MAN_W-1:0];
    a_nan = (&ea) & (|ma);
    b_nan = (&eb) & (|mb);
    a_inf = (&ea) & ~(|ma);
    b_inf = (&eb) & ~(|mb);
    ea_e  = (ea == '0) ? EXP_W'(1) : ea;
    eb_e  = (eb == '0) ? EXP_W'(1) : eb;
    b_gt  = in_b[W-2:0] > in_a[W-2:0];
    if (b_gt) begin
      el        = eb_e;
      es        = ea_e;
      ext_l     = {|eb, mb, 3'b000};
      ext_s     = {|ea, ma, 3'b000};
      s1_sign_d = sb;
    end else begin
      el        = ea_e;
      es        = eb_e;
      ext_l     = {|ea, ma, 3'b000};
      ext_s     = {|eb, mb, 3'b000};
      s1_sign_d = sa;
    end
    diff = el - es;
    wide = {ext_s, {FW{1'b0}}} >> diff;
    if (32'(diff) >= MAN_W + 3) begin
      sh_s = {{(FW-1){1'b0}}, |ext_s};
    end else begin
      sh_s = {wide[2*FW-1:FW+1], wide[FW] | (|wide[FW-1:0])};
    end
    s1_sub_d      = sa ^ sb;
    s1_nan_d      = a_nan | b_nan | (a_inf & b_inf & (sa ^ sb));
    s1_inf_d      = a_inf | b_inf;
    s1_inf_sign_d = a_inf ? sa : sb;
  end

  logic s1_valid_q, s1_sign_q, s1_sub_q, s1_nan_q, s1_inf_q, s1_inf_sign_q;
  logic [EXP_W-1:0] s1_exp_q;
  logic [FW-1:0] s1_ml_q, s1_ms_q;

  // Stage 2: magnitude add/subtract (never negative, larger operand first) and LZC.
  logic [SW-1:0] sum;
  logic [LZW-1:0] lzc;

  always_comb begin
    if (s1_sub_q) begin
      sum = {1'b0, s1_ml_q} - {1'b0, s1_ms_q};
    end else begin
      sum = {1'b0, s1_ml_q} + {1'b0, s1_ms_q};
    end
    lzc = LZW'(SW);
    for (int i = 0; i < SW; i++) begin
      if (sum[i]) lzc = LZW'(SW - 1 - i);
    end
  end

  logic s2_valid_q, s2_sign_q, s2_sub_q, s2_nan_q, s2_inf_q, s2_inf_sign_q;
  logic [EXP_W-1:0] s2_exp_q;
  logic [SW-1:0] s2_sum_q;
  logic [LZW-1:0] s2_lzc_q;

  // Stage 3: normalise, round to nearest even, pack and apply special-case overrides.
  logic [SHW-1:0] lz_m1, room, shl;
  logic [FW-1:0] shifted, nm;
  logic [EW-1:0] exp_n, exp_f;
  logic [PW-1:0] packed_v;
  logic rnd_up, inexact, ovf;
  logic [W-1:0] res_d;
  logic [2:0] flags_d;

  always_comb begin
    lz_m1 = SHW'(s2_lzc_q) - SHW'(1);
    room  = SHW'(s2_exp_q) - SHW'(1);
    // Left shift stops once the exponent reaches 1; the result is then subnormal.
    shl     = (lz_m1 < room) ? lz_m1 : room;
    shifted = s2_sum_q[FW-1:0] << shl;
    if (s2_sum_q[SW-1]) begin
      nm    = {s2_sum_q[SW-1:2], |s2_sum_q[1:0]};
      exp_n = {1'b0, s2_exp_q} + EW'(1);
    end else begin
      nm    = shifted;
      exp_n = {1'b0, s2_exp_q} - EW'(shl);
    end
    rnd_up   = nm[2] & (nm[1] | nm[0] | nm[3]);
    inexact  = |nm[2:0];
    exp_f    = nm[FW-1] ? exp_n : '0;
    // Rounding carry ripples from the mantissa into the exponent field naturally.
    packed_v = {exp_f, nm[FW-2:3]} + PW'(rnd_up);
    ovf      = packed_v[PW-1:MAN_W] >= {1'b0, {EXP_W{1'b1}}};

    res_d   = {s2_sign_q, packed_v[PW-2:0]};
    flags_d = {2'b00, inexact};
    if (s2_nan_q) begin
      res_d   = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
      flags_d = 3'b100;
    end else if (s2_inf_q) begin
      res_d   = {s2_inf_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      flags_d = 3'b000;
    end else if (s2_sum_q == '0) begin
      res_d   = {~s2_sub_q & s2_sign_q, {(W-1){1'b0}}};
      flags_d = 3'b000;
    end else if (ovf) begin
      res_d   = {s2_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      flags_d = 3'b011;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q   <= 1'b0;
      s2_valid_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_flags_q  <= '0;
    end else if (adv) begin
      s1_valid_q  <= in_valid;
      s2_valid_q  <= s1_valid_q;
      out_valid_q <= s2_valid_q;
      if (s2_valid_q) begin
        out_result_q <= res_d;
        out_flags_q  <= flags_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (adv) begin
      s1_sign_q     <= s1_sign_d;
      s1_sub_q      <= s1_sub_d;
      s1_nan_q      <= s1_nan_d;
      s1_inf_q      <= s1_inf_d;
      s1_inf_sign_q <= s1_inf_sign_d;
      s1_exp_q      <= el;
      s1_ml_q       <= ext_l;
      s1_ms_q       <= sh_s;
      s2_sign_q     <= s1_sign_q;
      s2_sub_q      <= s1_sub_q;
      s2_nan_q      <= s1_nan_q;
      s2_inf_q      <= s1_inf_q;
      s2_inf_sign_q <= s1_inf_sign_q;
      s2_exp_q      <= s1_exp_q;
      s2_sum_q      <= sum;
      s2_lzc_q      <= lzc;
    end
  end

endmodule
